// File: rtl/ttpu_pkg.sv
// ttpu_pkg: shared feeder constants and state encoding
package ttpu_pkg;
  localparam int MAX_N = 32;
  localparam int DATA_W = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} feeder_state_e;
endpackage

// File: rtl/skew_lane_mux.sv
// skew_lane_mux: picks buffer row t-LANE for one lane, zero outside the skew window or for inactive lanes
module skew_lane_mux import ttpu_pkg::*; #(
  parameter int MAX_N  = ttpu_pkg::MAX_N,
  parameter int DATA_W = ttpu_pkg::DATA_W,
  parameter int LANE   = 0
) (
  input  logic [MAX_N-1:0][DATA_W-1:0] col,
  input  logic [5:0]                   t,
  input  logic [5:0]                   n,
  output logic [DATA_W-1:0]            a
);
  localparam logic [5:0] L = 6'(LANE);
  localparam int IW = MAX_N > 1 ? $clog2(MAX_N) : 1;
  logic [5:0] d;
  assign d = t - L;
  assign a = (L < n && t >= L && d < n) ? col[d[IW-1:0]] : DATA_W'(FP16_ZERO);
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers N slices then streams them diagonally skewed to the array; SKEW_FEEDER_STALL_CNT_EN adds stall_cnt
module systolic_skew_feeder import ttpu_pkg::*; #(
  parameter int MAX_N  = ttpu_pkg::MAX_N,
  parameter int DATA_W = ttpu_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   matrix_N,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MAX_N-1:0][DATA_W-1:0] in_slice,
  input  logic                         arr_hold,
  output logic [MAX_N-1:0][DATA_W-1:0] a,
  output logic                         arr_en,
  output logic                         busy,
  output logic                         done,
`ifdef SKEW_FEEDER_STALL_CNT_EN
  output logic [15:0]                  stall_cnt,
`endif
  output logic                         err
);
  localparam logic [5:0] MAX_NC = 6'(MAX_N);
  localparam int IW = MAX_N > 1 ? $clog2(MAX_N) : 1;
  feeder_state_e state_q, state_d;
  logic [5:0] n_q, n_d, k_q, k_d, t_q, t_d;
  logic [MAX_N-1:0][DATA_W-1:0] a_q, a_d, lane_v;
  logic [MAX_N-1:0][MAX_N-1:0][DATA_W-1:0] mem_q, mem_d;
  logic arr_en_q, arr_en_d, done_q, done_d, err_q, err_d;
  logic valid_n, accept, last;
  assign valid_n = matrix_N != 6'd0 && matrix_N <= MAX_NC;
  assign accept = state_q == ST_LOAD && in_valid;
  assign last = t_q == n_q + n_q - 6'd2;
  for (genvar i = 0; i < MAX_N; i++) begin : g_lane
    logic [MAX_N-1:0][DATA_W-1:0] col;
    for (genvar r = 0; r < MAX_N; r++) begin : g_row
      assign col[r] = mem_q[r][i];
    end
    skew_lane_mux #(.MAX_N(MAX_N), .DATA_W(DATA_W), .LANE(i)) u_mux (
      .col(col), .t(t_q), .n(n_q), .a(lane_v[i])
    );
  end
  // next state: load slices, then issue 2N-1 skewed beats, freezing on hold; done trails the final beat
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    k_d = k_q;
    t_d = t_q;
    a_d = '0;
    arr_en_d = 1'b0;
    done_d = arr_en_q && state_q == ST_IDLE;
    err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = valid_n ? ST_LOAD : ST_IDLE;
        n_d = valid_n ? matrix_N : n_q;
        k_d = valid_n ? 6'd0 : k_q;
        err_d = !valid_n;
      end
      ST_LOAD: if (in_valid) begin
        k_d = k_q + 6'd1;
        state_d = k_q == n_q - 6'd1 ? ST_STREAM : ST_LOAD;
        t_d = 6'd0;
      end
      ST_STREAM: if (arr_hold) a_d = a_q;
      else begin
        a_d = lane_v;
        arr_en_d = 1'b1;
        t_d = t_q + 6'd1;
        state_d = last ? ST_IDLE : ST_STREAM;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q <= '0;
      k_q <= '0;
      t_q <= '0;
      a_q <= '0;
      arr_en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      k_q <= k_d;
      t_q <= t_d;
      a_q <= a_d;
      arr_en_q <= arr_en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // slice buffer write, row k on each accepted slice
  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[k_q[IW-1:0]] = in_slice;
  end
  // slice buffer storage, contents need no reset
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  // held stream cycles, cleared on an accepted start, saturating
  always_comb stall_d = (state_q == ST_IDLE && start && valid_n) ? 16'd0 :
                        (state_q == ST_STREAM && arr_hold && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  // stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
  assign a = a_q;
  assign arr_en = arr_en_q;
  assign busy = state_q != ST_IDLE;
  assign in_ready = state_q == ST_LOAD;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed stimulus against a cycle-level behavioural model of the feeder
module tb_systolic_skew_feeder;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, arr_hold = 1'b0;
  logic [5:0] matrix_N = 6'd0;
  logic [31:0][15:0] in_slice = '0;
  logic [31:0][15:0] a;
  logic in_ready, arr_en, busy, done, err;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, errors = 0;
  systolic_skew_feeder dut (
    .clk(clk), .reset(reset), .matrix_N(matrix_N), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_slice(in_slice), .arr_hold(arr_hold), .a(a), .arr_en(arr_en),
    .busy(busy), .done(done),
`ifdef SKEW_FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .err(err)
  );
  always #5 clk = ~clk;
  // model: phase 0 idle, 1 collecting slices, 2 streaming; expected outputs are those registered at this edge
  int ph = 0, m_n = 0, m_k = 0, m_t = 0;
  logic [15:0] m_stall = 16'd0;
  logic [31:0][15:0] mslc [32];
  logic [31:0][15:0] e_a = '0;
  bit e_en = 0, e_done = 0, e_err = 0, m_held = 0;
  function automatic logic [15:0] lane_val(input int t, input int i);
    return (i < m_n && t >= i && t - i < m_n) ? mslc[t-i][i] : 16'h0000;
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; m_n = 0; m_k = 0; m_t = 0; m_stall = 16'd0;
      e_a = '0; e_en = 0; e_done = 0; e_err = 0;
    end else begin
      m_held = ph == 2 && arr_hold;
      e_done = e_en && ph == 0;
      e_en = 0;
      e_err = 0;
      if (ph == 0 && start) begin
        if (int'(matrix_N) >= 1 && int'(matrix_N) <= 32) begin
          ph = 1; m_n = int'(matrix_N); m_k = 0; m_stall = 16'd0;
        end else e_err = 1;
      end else if (ph == 1 && in_valid) begin
        mslc[m_k] = in_slice;
        m_k++;
        if (m_k == m_n) begin ph = 2; m_t = 0; end
      end else if (m_held) begin
        if (m_stall != 16'hFFFF) m_stall++;
      end else if (ph == 2) begin
        for (int i = 0; i < 32; i++) e_a[i] = lane_val(m_t, i);
        e_en = 1;
        m_t++;
        if (m_t == 2 * m_n - 1) ph = 0;
      end
      if (!e_en && !m_held) e_a = '0;
    end
  end
  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask
  // compare every cycle and capture streamed beats
  bit chk_on = 0;
  int cap_n = 0, n_done = 0, n_err = 0;
  logic [31:0][15:0] cap [64];
  always @(negedge clk) if (chk_on) begin
    chk("a", a, e_a);
    chk("arr_en", arr_en, e_en);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("busy", busy, ph != 0);
    chk("in_ready", in_ready, ph == 1);
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (arr_en) begin
      if (cap_n < 64) cap[cap_n] = a;
      cap_n++;
    end
    if (done) n_done++;
    if (err) n_err++;
  end
  logic [31:0][15:0] vec [32];
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic op_start(input int n);
    start = 1'b1;
    matrix_N = 6'(n);
    cyc(1);
    start = 1'b0;
  endtask
  task automatic load(input int n, input bit gap);
    for (int r = 0; r < n; r++) begin
      in_valid = 1'b1;
      in_slice = vec[r];
      cyc(1);
      if (gap) begin in_valid = 1'b0; cyc(1); end
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_cap(input int n);
    for (int c = 0; c < 300; c++) begin
      if (cap_n >= n) return;
      cyc(1);
    end
    checks++; errors++;
    $display("FAIL wait_cap got %0d exp %0d", cap_n, n);
  endtask
  task automatic wait_done();
    int d0 = n_done;
    for (int c = 0; c < 300; c++) begin
      if (n_done > d0) return;
      cyc(1);
    end
    checks++; errors++;
    $display("FAIL wait_done got %0d exp %0d", n_done, d0 + 1);
  endtask
  initial begin
    int d0;
    cyc(3);
    chk_on = 1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_a", a, 512'd0);
    reset = 1'b0;
    cyc(2);
    op_start(0);
    cyc(2);
    op_start(33);
    cyc(2);
    chk("err_pulses", n_err, 2);
    chk("err_busy", busy, 1'b0);
    chk("err_in_ready", in_ready, 1'b0);
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < 32; i++) vec[r][i] = 16'hFFFF;
    for (int r = 0; r < 4; r++) vec[r][3:0] = {16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
    cap_n = 0;
    d0 = n_done;
    op_start(4);
    load(4, 0);
    wait_done();
    chk("basic_beats", cap_n, 7);
    chk("basic_done", n_done, d0 + 1);
    chk("basic_t0_l0", cap[0][0], 16'h3C00);
    chk("basic_t0_l1", cap[0][1], 16'h0000);
    chk("basic_t3_l3", cap[3][3], 16'h4000);
    chk("basic_t6_l3", cap[6][3], 16'h4000);
    chk("basic_t6_l2", cap[6][2], 16'h0000);
    chk("basic_t2_l5", cap[2][5], 16'h0000);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 32; i++) vec[r][i] = 16'(16'h1000 + r * 16 + i);
    cap_n = 0;
    op_start(4);
    load(4, 0);
    cyc(2);
    arr_hold = 1'b1;
    cyc(3);
    arr_hold = 1'b0;
    wait_cap(7);
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("hold_stall_cnt", stall_cnt, 16'd3);
`endif
    chk("hold_beats", cap_n, 7);
    chk("hold_t3_l1", cap[3][1], 16'h1021);
    for (int i = 0; i < 32; i++) vec[0][i] = 16'h1234;
    vec[0][0] = 16'h4400;
    cap_n = 0;
    op_start(1);
    chk("start_in_done", in_ready, 1'b1);
    load(1, 0);
    wait_done();
    chk("n1_beats", cap_n, 1);
    chk("n1_l0", cap[0][0], 16'h4400);
    chk("n1_l1", cap[0][1], 16'h0000);
    cap_n = 0;
    for (int i = 0; i < 32; i++) vec[0][i] = 16'h1234;
    op_start(4);
    load(4, 0);
    wait_cap(3);
    reset = 1'b1;
    d0 = n_done;
    cyc(2);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_arr_en", arr_en, 1'b0);
    chk("mid_rst_a", a, 512'd0);
    reset = 1'b0;
    cyc(4);
    chk("mid_rst_no_done", n_done, d0);
    cap_n = 0;
    op_start(2);
    load(2, 0);
    wait_done();
    chk("n2_beats", cap_n, 3);
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < 32; i++) vec[r][i] = 16'(r * 32 + i + 1);
    cap_n = 0;
    op_start(32);
    load(32, 1);
    wait_done();
    chk("n32_beats", cap_n, 63);
    chk("n32_l31_t30", cap[30][31], 16'h0000);
    chk("n32_l31_t31", cap[31][31], 16'h0020);
    chk("n32_l0_t0", cap[0][0], 16'h0001);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter MAX_N, default 32, maximum array dimension (lanes).
REQ-002 The block SHALL have parameter DATA_W, default 16, element width (FP16 bit pattern, passed through unmodified).
REQ-003 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 Port list:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- matrix_N  in  6  active dimension N; sampled only in IDLE when start=1.
- start  in  1  one-cycle request to begin loading a new operand.
- in_valid  in  1  slice on in_slice is valid.
- in_ready  out  1  feeder accepts a slice this cycle.
- in_slice  in  MAX_N x DATA_W  one slice; element i is destined for lane i.
- arr_hold  in  1  array back-pressure; freezes streaming while high.
- a  out  MAX_N x DATA_W  skewed lane outputs to the systolic array.
- arr_en  out  1  a[] is valid for the array this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last streamed cycle.
- err  out  1  one-cycle pulse on a rejected start.

Function
REQ-005 States SHALL be IDLE, LOAD and STREAM.
REQ-006 IDLE: on start=1 with 1<=matrix_N<=MAX_N, latch N into n_q, clear the slice counter k, and go to LOAD.
REQ-007 IDLE: on start=1 with matrix_N=0 or matrix_N>MAX_N, pulse err the next cycle and stay in IDLE.
REQ-008 LOAD: in_ready=1; on in_valid&&in_ready, store in_slice in buffer row k and increment k.
REQ-009 LOAD: when slice N-1 is accepted, go to STREAM with cycle counter t=0; in_ready is 0 from the next cycle.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 STREAM: for each lane i<N, a[i] SHALL equal buf[t-i][i] when 0<=t-i<N, else 16'h0000.
REQ-012 Lanes i>=N SHALL output 16'h0000 at all times.
REQ-013 a[] and arr_en SHALL be registered outputs; the value for t appears the cycle after the counter equals t.
REQ-014 STREAM length SHALL be 2N-1 cycles with arr_en=1; the first arr_en comes exactly one cycle after the LOAD->STREAM transition.
REQ-015 arr_hold=1 SHALL freeze t, hold a[], and drive arr_en=0; streaming resumes with the same t when arr_hold falls.
REQ-016 After t=2N-2 is issued, return to IDLE and pulse done for one cycle; a start in the done cycle SHALL be accepted.
REQ-017 N=1 SHALL stream a single cycle, with a[0]=buf[0][0].
REQ-018 Outside STREAM, a[] SHALL be all 16'h0000 and arr_en=0.

Reset
REQ-019 While reset=1, the block SHALL be in state IDLE.
REQ-020 While reset=1, the block SHALL drive in_ready=0, arr_en=0, busy=0, done=0 and err=0, and a[] all 16'h0000.
REQ-021 While reset=1, counters k, t and n_q SHALL be 0; buffer contents need not be reset.
REQ-022 Reset asserted mid-LOAD or mid-STREAM SHALL abort the operation immediately, with no done pulse.

Configuration
REQ-023 With SKEW_FEEDER_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), which counts STREAM cycles with arr_hold=1.
REQ-024 stall_cnt SHALL clear on an accepted start, saturate at 16'hFFFF, and reset to 0.
REQ-025 Without SKEW_FEEDER_STALL_CNT_EN, neither the port nor the counter SHALL exist.

Structure
REQ-026 Shared package ttpu_pkg SHALL hold DATA_W, MAX_N, FP16_ZERO (16'h0000) and the feeder state enum.
REQ-027 Skew index/zero-select logic SHALL be one sub-module, skew_lane_mux, instanced per lane.
REQ-028 The buffer and FSM SHALL be in the top module.

Verification
REQ-029 N=4; slices 0-3 = {3C00,3C00,3C00,4000}; no hold -> a[0]=3C00 at t0-3, a[1]=3C00 at t1-4, a[2]=3C00 at t2-5, a[3]=4000 at t3-6, zero elsewhere; arr_en for 7 cycles; done 1 cycle after.
REQ-030 start with matrix_N=0, then with matrix_N=33 -> err pulses each time; state stays IDLE; in_ready stays 0.
REQ-031 N=4, arr_hold=1 for 3 cycles at t=2 -> a[] frozen; arr_en=0; total arr_en count is still 7 (stall_cnt=3 with SKEW_FEEDER_STALL_CNT_EN).
REQ-032 N=1, slice0[0]=4400 -> exactly one arr_en cycle with a[0]=4400; all other lanes 0.
REQ-033 reset pulsed at t=3 of an N=4 stream -> outputs reach reset values; no done pulse; a new start with N=2 then completes in 3 streamed cycles.
REQ-034 in_valid toggled 1,0,1,0 during LOAD with N=32 -> exactly 32 slices stored; STREAM lasts 63 cycles; lane 31 first non-zero at t=31.
